// File: rtl/ram_loader_s18_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_loader_s18_if
//  Purpose  : Bundles the byte-stream handshake and the 1Kx18 block-RAM port
//             driven by ram_loader_s18.
//  Signals  : s_data/s_valid/s_ready - byte stream (valid/ready)
//             ram_addr/ram_di/ram_dip/ram_en/ram_we/ram_ssr - RAM port inputs
//             ram_do/ram_dop - RAM read data / parity
//  Modports : master - the loader (drives s_ready and the RAM controls)
//             slave  - the environment (stream source and the RAM itself)
//  Revision : 1.0 - initial release
// ============================================================================
interface ram_loader_s18_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_di;
  logic [1:0]        ram_dip;
  logic              ram_en;
  logic              ram_we;
  logic              ram_ssr;
  logic [15:0]       ram_do;
  logic [1:0]        ram_dop;

  modport master (
    input  s_data, s_valid, ram_do, ram_dop,
    output s_ready, ram_addr, ram_di, ram_dip, ram_en, ram_we, ram_ssr
  );

  modport slave (
    output s_data, s_valid, ram_do, ram_dop,
    input  s_ready, ram_addr, ram_di, ram_dip, ram_en, ram_we, ram_ssr
  );
endinterface
`default_nettype wire

// File: rtl/ram_loader_s18.sv
`default_nettype none
// ============================================================================
//  Module   : ram_loader_s18
//  Purpose  : Loads a program image into a 1Kx18 single-port block RAM from a
//             byte stream (3 bytes per word), reads it back and compares a
//             rolling checksum, holding the processor in reset until done.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset
//             start - one-cycle pulse, begins a load (IDLE/FIN only)
//             bus   - stream handshake + RAM port (master modport)
//             busy  - load or verify in progress
//             done  - level, last load finished
//             err   - level, last verify mismatched (valid with done)
//             hold  - processor reset request
//  Revision : 1.0 - initial release
// ============================================================================
module ram_loader_s18 #(
  parameter int ADDR_W = 10,
  parameter int WORDS  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  ram_loader_s18_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                hold
);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_collect = 3'd1;
  localparam logic [2:0] c_write   = 3'd2;
  localparam logic [2:0] c_vrd     = 3'd3;
  localparam logic [2:0] c_vlast   = 3'd4;
  localparam logic [2:0] c_fin     = 3'd5;

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(WORDS - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [1:0]        r_bidx;
  logic [1:0]        r_dip;
  logic [15:0]       r_di;
  logic [17:0]       r_cw;
  logic [17:0]       r_cr;
  logic              r_rd_pend;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_hold;

  logic              w_ready;
  logic              w_xfer;
  logic [17:0]       w_cw_next;
  logic [17:0]       w_cr_next;

  assign w_ready   = (r_state == c_collect);
  assign w_xfer    = w_ready && bus.s_valid;
  // Rotate-then-XOR makes both checksums sensitive to word order.
  assign w_cw_next = {r_cw[16:0], r_cw[17]} ^ {r_dip, r_di};
  assign w_cr_next = {r_cr[16:0], r_cr[17]} ^ {bus.ram_dop, bus.ram_do};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_cnt     <= '0;
      r_bidx    <= 2'd0;
      r_dip     <= 2'd0;
      r_di      <= 16'd0;
      r_cw      <= 18'd0;
      r_cr      <= 18'd0;
      r_rd_pend <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_hold    <= 1'b1;
    end else begin
      // One-cycle read latency: data for a read issued in VRD arrives next cycle.
      r_rd_pend <= (r_state == c_vrd);
      if (r_rd_pend) begin
        r_cr <= w_cr_next;
      end

      case (r_state)
        c_idle, c_fin: begin
          if (start) begin
            r_state <= c_collect;
            r_cnt   <= '0;
            r_bidx  <= 2'd0;
            r_cw    <= 18'd0;
            r_cr    <= 18'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_hold  <= 1'b1;
          end
        end

        c_collect: begin
          if (w_xfer) begin
            case (r_bidx)
              2'd0: begin
                r_dip  <= bus.s_data[1:0];
                r_bidx <= 2'd1;
              end
              2'd1: begin
                r_di[15:8] <= bus.s_data;
                r_bidx     <= 2'd2;
              end
              default: begin
                r_di[7:0] <= bus.s_data;
                r_bidx    <= 2'd0;
                r_state   <= c_write;
              end
            endcase
          end
        end

        c_write: begin
          r_cw <= w_cw_next;
          if (r_cnt == c_last) begin
            r_cnt   <= '0;
            r_state <= c_vrd;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= c_collect;
          end
        end

        c_vrd: begin
          if (r_cnt == c_last) begin
            r_cnt   <= '0;
            r_state <= c_vlast;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        c_vlast: begin
          // The final sample is folded in this cycle, so compare the next value.
          r_state <= c_fin;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_err   <= (w_cr_next != r_cw);
          r_hold  <= (w_cr_next != r_cw);
        end

        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.s_ready  = w_ready;
  assign bus.ram_addr = r_cnt;
  assign bus.ram_di   = r_di;
  assign bus.ram_dip  = r_dip;
  assign bus.ram_en   = (r_state == c_write) || (r_state == c_vrd);
  assign bus.ram_we   = (r_state == c_write);
  assign bus.ram_ssr  = 1'b0;

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
  assign hold = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_ram_loader_s18.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_loader_s18
//  Purpose  : Self-checking bench for ram_loader_s18 with behavioural RAMs;
//             a 4-word instance and a 1024-word instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_loader_s18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start4, start1k;
  logic busy4, done4, err4, hold4;
  logic busy1k, done1k, err1k, hold1k;

  ram_loader_s18_if #(.ADDR_W(10)) if4 ();
  ram_loader_s18_if #(.ADDR_W(10)) if1k ();

  ram_loader_s18 #(.ADDR_W(10), .WORDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bus(if4),
    .busy(busy4), .done(done4), .err(err4), .hold(hold4)
  );

  ram_loader_s18 #(.ADDR_W(10), .WORDS(1024)) u_dut1k (
    .clk(clk), .rst_n(rst_n), .start(start1k), .bus(if1k),
    .busy(busy1k), .done(done1k), .err(err1k), .hold(hold1k)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural RAMs ----------------
  logic [17:0] mem4 [0:1023];
  logic [17:0] mem1k[0:1023];
  logic [17:0] rd4_q, rd1k_q;
  bit          corrupt = 1'b0;
  bit          clr4    = 1'b0;

  always @(posedge clk) begin
    if (clr4) begin
      for (int i = 0; i < 4; i++) mem4[i] <= 18'd0;
    end else if (if4.ram_en) begin
      if (if4.ram_we) mem4[if4.ram_addr] <= {if4.ram_dip, if4.ram_di};
      else rd4_q <= mem4[if4.ram_addr] ^ ((corrupt && if4.ram_addr == 10'd2) ? 18'd1 : 18'd0);
    end
  end
  assign if4.ram_do  = rd4_q[15:0];
  assign if4.ram_dop = rd4_q[17:16];

  always @(posedge clk) begin
    if (if1k.ram_en) begin
      if (if1k.ram_we) mem1k[if1k.ram_addr] <= {if1k.ram_dip, if1k.ram_di};
      else rd1k_q <= mem1k[if1k.ram_addr];
    end
  end
  assign if1k.ram_do  = rd1k_q[15:0];
  assign if1k.ram_dop = rd1k_q[17:16];

  // ---------------- scoreboards and monitors ----------------
  logic [27:0] q4[$], q1k[$];
  logic [7:0]  strm[0:3071];
  int gcyc = 0;
  always @(posedge clk) gcyc++;

  int wr4 = 0, rdn4 = 0, we_long = 0, rdy_in_write = 0;
  int wt4[$];
  bit we4_prev = 1'b0;
  always @(negedge clk) begin
    if (if4.ram_we) begin
      wr4++;
      wt4.push_back(gcyc);
      if (if4.s_ready) rdy_in_write++;
      if (q4.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr4_unexpected: write addr 0x%0h data 0x%0h, expected no write",
                 if4.ram_addr, {if4.ram_dip, if4.ram_di});
      end else begin
        chk("wr4_word", {4'd0, if4.ram_addr, if4.ram_dip, if4.ram_di}, {4'd0, q4.pop_front()});
      end
    end
    if (if4.ram_we && we4_prev) we_long++;
    we4_prev = if4.ram_we;
    if (if4.ram_en && !if4.ram_we) rdn4++;
  end

  int wr1k = 0, rdn1k = 0, rdfirst = 0, rdlast = 0;
  logic [9:0] lastwa1k = '0;
  always @(negedge clk) begin
    if (if1k.ram_we) begin
      wr1k++;
      lastwa1k = if1k.ram_addr;
      if (q1k.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr1k_unexpected: write addr 0x%0h, expected no write", if1k.ram_addr);
      end else begin
        chk("wr1k_word", {4'd0, if1k.ram_addr, if1k.ram_dip, if1k.ram_di}, {4'd0, q1k.pop_front()});
      end
    end
    if (if1k.ram_en && !if1k.ram_we) begin
      if (rdn1k == 0) rdfirst = gcyc;
      rdlast = gcyc;
      rdn1k++;
    end
  end

  // {busy, done, err, hold}
  function automatic logic [3:0] stat(input bit sel);
    return sel ? {busy1k, done1k, err1k, hold1k} : {busy4, done4, err4, hold4};
  endfunction

  // Start a load on one instance and feed nwords words from strm[].
  task automatic run_load(input bit sel, input int nwords, input bit toggle, input bit vrd_start);
    int idx = 0;
    int cyc = 0;
    bit poked = 1'b0;
    bit v;
    bit rdy;
    bit rd_issue;
    logic [9:0] ka;
    @(negedge clk);
    if (sel) start1k = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start1k = 1'b0;
    chk(sel ? "start_clears_1k" : "start_clears_4", {28'd0, stat(sel)}, 32'b1001);
    while (1) begin
      if (stat(sel)[2]) break;
      if (cyc > 20000) begin
        n_checks++; n_fail++;
        $display("FAIL load_timeout: done=0 after %0d cycles, expected done=1", cyc);
        break;
      end
      start4 = 1'b0; start1k = 1'b0;
      rdy      = sel ? if1k.s_ready : if4.s_ready;
      rd_issue = sel ? (if1k.ram_en && !if1k.ram_we) : (if4.ram_en && !if4.ram_we);
      if (vrd_start && !poked && rd_issue) begin
        poked = 1'b1;
        if (sel) start1k = 1'b1; else start4 = 1'b1;
      end
      v = (idx < 3 * nwords) && (!toggle || cyc[0]);
      if (sel) begin
        if1k.s_valid = v; if1k.s_data = v ? strm[idx] : 8'h00;
      end else begin
        if4.s_valid = v;  if4.s_data  = v ? strm[idx] : 8'h00;
      end
      if (v && rdy) begin
        idx++;
        if (idx % 3 == 0) begin
          ka = 10'(idx / 3 - 1);
          if (sel) q1k.push_back({ka, strm[idx-3][1:0], strm[idx-2], strm[idx-1]});
          else     q4.push_back({ka, strm[idx-3][1:0], strm[idx-2], strm[idx-1]});
        end
      end
      @(negedge clk);
      cyc++;
    end
    if4.s_valid = 1'b0; if1k.s_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [17:0] w;
  } vec_t;
  vec_t tbl[4];

  int w0, r0;

  initial begin
    tbl[0] = '{8'h03, 8'h12, 8'h34, 18'h31234};
    tbl[1] = '{8'h00, 8'hAB, 8'hCD, 18'h0ABCD};
    tbl[2] = '{8'h01, 8'h00, 8'h01, 18'h10001};
    tbl[3] = '{8'h02, 8'hFF, 8'hFF, 18'h2FFFF};

    rst_n = 1'b0; start4 = 1'b0; start1k = 1'b0;
    if4.s_valid = 1'b0;  if4.s_data = 8'h00;
    if1k.s_valid = 1'b0; if1k.s_data = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_s_ready",  {31'd0, if4.s_ready}, 32'd0);
    chk("rst_en_we",    {30'd0, if4.ram_en, if4.ram_we}, 32'd0);
    chk("rst_addr",     {22'd0, if4.ram_addr}, 32'd0);
    chk("rst_di_dip",   {14'd0, if4.ram_dip, if4.ram_di}, 32'd0);
    chk("rst_ssr",      {31'd0, if4.ram_ssr}, 32'd0);
    chk("rst_status",   {28'd0, stat(1'b0)}, 32'b0001);
    chk("rst_status1k", {28'd0, stat(1'b1)}, 32'b0001);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      strm[3*i] = tbl[i].b0; strm[3*i+1] = tbl[i].b1; strm[3*i+2] = tbl[i].b2;
    end

    // Run A: continuous stream
    w0 = wr4; r0 = rdn4; wt4.delete();
    run_load(1'b0, 4, 1'b0, 1'b0);
    chk("A_writes", wr4 - w0, 4);
    chk("A_reads", rdn4 - r0, 4);
    for (int i = 1; i < 4; i++) chk("A_cycles_per_word", wt4[i] - wt4[i-1], 4);
    for (int i = 0; i < 4; i++) chk("A_mem", {14'd0, mem4[i]}, {14'd0, tbl[i].w});
    chk("A_status", {28'd0, stat(1'b0)}, 32'b0100);

    // Run B: read-back corruption at address 2
    corrupt = 1'b1;
    run_load(1'b0, 4, 1'b0, 1'b0);
    chk("B_status", {28'd0, stat(1'b0)}, 32'b0111);
    corrupt = 1'b0;

    // Run C: restart from FIN with an error pending, stalling stream
    clr4 = 1'b1; @(negedge clk); clr4 = 1'b0;
    run_load(1'b0, 4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk("C_mem", {14'd0, mem4[i]}, {14'd0, tbl[i].w});
    chk("C_status", {28'd0, stat(1'b0)}, 32'b0100);
    chk("C_ready_in_write", rdy_in_write, 0);
    chk("C_queue_drained", q4.size(), 0);

    // Run D: START during verify is ignored
    w0 = wr4; r0 = rdn4;
    run_load(1'b0, 4, 1'b0, 1'b1);
    chk("D_writes", wr4 - w0, 4);
    chk("D_reads", rdn4 - r0, 4);
    chk("D_status", {28'd0, stat(1'b0)}, 32'b0100);

    // Full 1024-word image
    for (int i = 0; i < 3072; i++) strm[i] = 8'($urandom);
    run_load(1'b1, 1024, 1'b0, 1'b0);
    chk("K_writes", wr1k, 1024);
    chk("K_last_addr", {22'd0, lastwa1k}, 32'h3FF);
    chk("K_reads", rdn1k, 1024);
    chk("K_read_span", rdlast - rdfirst, 1023);
    chk("K_status", {28'd0, stat(1'b1)}, 32'b0100);

    // Asynchronous reset in the middle of COLLECT
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0; if4.s_valid = 1'b1; if4.s_data = 8'h03;
    @(negedge clk); if4.s_data = 8'h12;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("R_s_ready", {31'd0, if4.s_ready}, 32'd0);
    chk("R_en_we",   {30'd0, if4.ram_en, if4.ram_we}, 32'd0);
    chk("R_di_dip",  {14'd0, if4.ram_dip, if4.ram_di}, 32'd0);
    chk("R_status",  {28'd0, stat(1'b0)}, 32'b0001);
    w0 = wr4;
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("R_no_write", wr4 - w0, 0);
    chk("R_idle_ready", {31'd0, if4.s_ready}, 32'd0);
    if4.s_valid = 1'b0;

    chk("we_single_cycle", we_long, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_loader_s18.md
Name: ram_loader_s18

Overview:
- Writer/master for a 1Kx18 single-port block RAM port (ADDR/DI/DIP/EN/WE/SSR in, DO/DOP out), e.g. the PicoBlaze program store.
- Accepts a byte stream over a valid/ready handshake and packs every 3 bytes into one 18-bit word.
- Writes the words to sequential addresses, then reads the whole image back and checks a rolling checksum.
- Holds the processor in reset (HOLD) until the image is loaded and verified.

Parameters:
- ADDR_W, 10, RAM address width.
- WORDS, 1024, words per image; 1..2**ADDR_W.

Ports:
- CLK  in  1  clock; all logic rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse; begins a load.
- S_DATA  in  8  stream byte.
- S_VALID  in  1  S_DATA valid.
- S_READY  out  1  block accepts S_DATA this cycle.
- RAM_ADDR  out  ADDR_W  RAM address.
- RAM_DI  out  16  RAM write data.
- RAM_DIP  out  2  RAM write parity bits.
- RAM_EN  out  1  RAM enable.
- RAM_WE  out  1  RAM write enable.
- RAM_SSR  out  1  RAM output set/reset; constant 0.
- RAM_DO  in  16  RAM read data.
- RAM_DOP  in  2  RAM read parity.
- BUSY  out  1  load or verify in progress.
- DONE  out  1  level; last load finished.
- ERR  out  1  level; last verify mismatched; valid when DONE=1.
- HOLD  out  1  processor-reset request.

Behaviour:
- Reset values: S_READY=0, RAM_ADDR=0, RAM_DI=0, RAM_DIP=0, RAM_EN=0, RAM_WE=0, RAM_SSR=0, BUSY=0, DONE=0, ERR=0, HOLD=1; internal counters and checksums 0. Reset mid-load aborts with no further RAM writes.
- States: IDLE, COLLECT, WRITE, VRD, VLAST, FIN.
- Transfer occurs when S_VALID=1 and S_READY=1. S_READY=1 only in COLLECT.
- Byte order per word:
  - byte0[1:0] -> DIP; byte0[7:2] ignored.
  - byte1 -> DI[15:8].
  - byte2 -> DI[7:0].
- IDLE or FIN + START: go to COLLECT; clear word counter, byte index, both checksums, DONE, ERR; BUSY=1, HOLD=1. START is ignored in every other state.
- COLLECT: after the 3rd byte is accepted, go to WRITE on the next edge.
- WRITE lasts exactly one cycle:
  - Drives EN=1, WE=1, ADDR=word counter, DI/DIP = assembled word.
  - Updates the write checksum: cw <= {cw[16:0],cw[17]} ^ {DIP,DI}.
  - If word counter = WORDS-1: clear counter, go to VRD. Otherwise increment counter and return to COLLECT.
- Minimum cost per word: 4 cycles (3 accept cycles + 1 write cycle).
- VRD issues one read per cycle with EN=1, WE=0, ADDR=counter.
- RAM read latency is 1 cycle: the data for the read issued in cycle t is sampled from DO/DOP in cycle t+1, i.e. the read-checksum update lags issue by one cycle. Read checksum: cr <= {cr[16:0],cr[17]} ^ {DOP,DO}, same rotate-XOR as cw.
- Leaving VRD: when the read for address WORDS-1 is issued, go to VLAST. VLAST: EN=0; absorbs the final sample.
- VLAST -> FIN: DONE=1, BUSY=0, ERR = (cr != cw) evaluated after the final sample, HOLD = ERR.
- FIN holds until START or reset.
- RAM_EN=0 and RAM_WE=0 in IDLE, COLLECT and FIN. RAM_WE is never 1 outside WRITE.
- The checksum rotation makes it order-sensitive: a swapped pair of words is detected.
- WORDS=1: a single write, a single read, then VLAST.
- Address wrap: the counter never exceeds WORDS-1. With WORDS=2**ADDR_W the last address is all ones and there is no wrap write.
- Stalls: S_VALID low in COLLECT simply waits, with no timeout. Partial byte index and counters are held.

Test Plan:
- Reset with RST_N=0 mid-COLLECT -> all outputs at reset values immediately (async), HOLD=1, no RAM_WE pulse afterwards.
- WORDS=4, stream 03 12 34 / 00 AB CD / 01 00 01 / 02 FF FF, S_VALID always 1, behavioural RAM model -> writes 0x31234@0, 0x0ABCD@1, 0x10001@2, 0x2FFFF@3; each WE one cycle; 4 cycles/word; DONE=1, ERR=0, HOLD=0.
- Same image, but the model corrupts DO bit 0 at address 2 on read -> DONE=1, ERR=1, HOLD=1.
- Same image with S_VALID toggling every other cycle -> identical RAM contents; S_READY low during WRITE; no byte lost or duplicated.
- START pulsed during VRD -> ignored; completes normally. START in FIN -> DONE/ERR clear next cycle and a new load runs.
- WORDS=1024, random image -> last write at ADDR=0x3FF; 1024 verify reads in consecutive cycles; ERR=0.
